// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives the registered program ROM,
// and hands each instruction to the decoder. Supports PC-relative branches, stalls and halt-on-self-branch.
module fetch_unit #(
    parameter int PC_WIDTH     = 6,
    parameter int INSTR_WIDTH  = 20,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    pc_rel_branch,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0]  imem_data,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic [5:0]              opcode,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    instr_valid,
    output logic                    halted
);

    typedef enum logic [1:0] {
        FILL,
        RUN,
        HALT
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t              state;
    logic [PC_WIDTH-1:0] fpc;
    logic [PC_WIDTH-1:0] target;
    logic                in_run;
    logic                take;

    assign in_run = (state == RUN);
    assign take   = in_run && pc_rel_branch && !stall;
    assign target = pc + branch_offset[PC_WIDTH-1:0];

    // While stalled the ROM re-reads the presented address so instr stays stable.
    assign imem_addr = (in_run && stall) ? pc : fpc;
    assign instr     = imem_data;
    assign opcode    = imem_data[INSTR_WIDTH-1 -: 6];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            fpc         <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    pc          <= fpc;
                    fpc         <= fpc + PC_ONE;
                    instr_valid <= 1'b1;
                    state       <= RUN;
                end
                RUN: begin
                    if (stall) begin
                        state <= RUN;
                    end else if (take && (branch_offset == '0)) begin
                        fpc         <= pc;
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                        state       <= HALT;
                    end else if (take) begin
                        // The word already in flight from the ROM is dropped by this bubble.
                        fpc         <= target;
                        instr_valid <= 1'b0;
                        state       <= FILL;
                    end else begin
                        pc          <= fpc;
                        fpc         <= fpc + PC_ONE;
                        instr_valid <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
